pipelined_adder_tree: RTL
=========================

# pipelined_adder_tree

Parametrised, pipelined successor to the combinational 9-input convolver adder tree. It sums NUM_INPUTS signed operands plus a bias through a balanced binary tree with one register stage per tree level. Flow control is valid/ready, and the output is saturated or wrapped to DATA_WIDTH. It sits between the multiplier array and the activation stage of the convolver datapath, and can be reused for any kernel size.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each operand, bias and result (signed two's complement)
- NUM_INPUTS, 9, number of data operands, legal range 1..64; bias is always an extra operand
- SATURATE, 1, 1 = clamp result to DATA_WIDTH signed range; 0 = wrap (keep low DATA_WIDTH bits)

Derived values (not overridable):
- OPS = NUM_INPUTS+1
- LEVELS = ceil(log2(OPS)), with a minimum of 1
- ACC_WIDTH = DATA_WIDTH+LEVELS

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- valid_in  input  1  operand vector and bias valid this cycle
- ready_in  output  1  block accepts a vector this cycle
- data_in  input  NUM_INPUTS*DATA_WIDTH  packed operands; operand i is data_in[i*DATA_WIDTH +: DATA_WIDTH]
- bias  input  DATA_WIDTH  signed bias, sampled with data_in
- valid_out  output  1  result valid
- ready_out  input  1  downstream accepts result
- result  output  DATA_WIDTH  signed sum
- overflow  output  1  full-precision sum fell outside DATA_WIDTH range (reported in both SATURATE modes)

## Operation
- Level 0 operand list: data_in[0..NUM_INPUTS-1], then bias as the last operand. Each operand is sign-extended to ACC_WIDTH.
- Each level pairs adjacent operands (0+1, 2+3, ...). If a level has an odd count, the last operand passes to the next level unchanged. The pass-through operand is registered like the sums, so every path has equal latency.
- Each level's outputs are registered, giving LEVELS pipeline stages. Each stage holds a valid bit.
- Internal width is ACC_WIDTH everywhere, so no intermediate overflow is possible.
- Final stage, with S the full-precision ACC_WIDTH sum:
  - overflow = (S > 2^(DATA_WIDTH-1)-1) or (S < -2^(DATA_WIDTH-1)).
  - SATURATE=1: result is clamped to 0x7FF..F or 0x800..0 on overflow; otherwise result = S[DATA_WIDTH-1:0].
  - SATURATE=0: result = S[DATA_WIDTH-1:0] always.
- Saturation and overflow are combinational from the last stage register.
- Flow control uses a global stall: advance = ~valid_out | ready_out.
  - ready_in = advance.
  - When advance=1, every stage loads from its predecessor. Stage 0 loads from the inputs, with valid = valid_in.
  - When advance=0, all stages hold data and valid bits.
- A vector transfers in when valid_in & ready_in. A result transfers out when valid_out & ready_out.
- Bubbles (valid=0 stages) propagate and are not compressed.
- Data registers of invalid stages may change freely. Only valid-qualified data is specified.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits clear to 0. This gives valid_out=0 and ready_in=1 immediately, without waiting for a clock edge.
  - Data registers also clear to 0, so result=0 and overflow=0.
- Latency: with ready_out held 1, a vector accepted at edge k appears on result/valid_out after edge k+LEVELS-1, and is consumed at edge k+LEVELS.
  - Default: LEVELS=4 (10→5→3→2→1).
- Throughput is one vector per cycle while ready_out=1.
- Holding ready_out=0 while valid_out=1 freezes the pipeline.
  - result and overflow stay stable.
  - ready_in=0, and valid_in is ignored that cycle.
- Simultaneous output transfer and input accept in the same cycle is the normal streaming case; no data is lost or duplicated.
- Reset asserted mid-stream discards all in-flight vectors. The first valid_out after release belongs to a vector accepted after release.
- NUM_INPUTS=1 gives OPS=2 and LEVELS=1, a single registered add of data plus bias.

## Test plan
- Reset: assert rst_n=0 mid-stream with pipeline full -> valid_out=0, ready_in=1, result=0 without a clock edge; after release, no stale results emerge.
- Basic sum, defaults: data_in = 1..9, bias=10, ready_out=1 -> result=55, overflow=0, valid_out high 4 cycles after accept.
  - Repeat with data_in all -1 and bias=-7 -> result=-16.
- Positive saturation: all operands and bias 0x7FFFFFFF.
  - SATURATE=1 -> result=0x7FFFFFFF, overflow=1.
  - SATURATE=0 -> result=0xFFFFFFF6 (-10), overflow=1.
- Negative saturation: all operands and bias 0x80000000.
  - SATURATE=1 -> result=0x80000000, overflow=1.
  - SATURATE=0 -> result=0x00000000, overflow=1.
- Backpressure: stream 6 vectors back-to-back (sums 10,20,...,60), drop ready_out for 3 cycles while valid_out=1 -> ready_in=0 during the stall, result held stable, all 6 sums delivered in order with no loss or duplication.
- Parameter sweep: NUM_INPUTS in {1,2,3,8,16,25} with random operands and random valid_in/ready_out -> every result matches a reference sum, with saturation per SATURATE; latency = LEVELS cycles when unstalled.

Source files
------------

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: balanced binary adder tree over NUM_INPUTS operands plus bias, one register stage per level,
// valid/ready flow control with a global stall, saturating or wrapping output.
module pipelined_adder_tree #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 9,
  parameter int SATURATE = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0]            bias,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [DATA_WIDTH-1:0]            result,
  output logic                             overflow
);
  localparam int OPS = NUM_INPUTS + 1;
  localparam int LEVELS = (OPS > 2) ? $clog2(OPS) : 1;
  localparam int ACC_WIDTH = DATA_WIDTH + LEVELS;
  localparam int W = OPS + 1;
  function automatic int cnt_in(input int l);
    int c;
    c = OPS;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction
  logic signed [ACC_WIDTH-1:0] src [LEVELS][W];
  logic signed [ACC_WIDTH-1:0] nxt [LEVELS][W];
  logic signed [ACC_WIDTH-1:0] stg [LEVELS][W];
  logic [LEVELS-1:0] vld;
  logic advance;
  logic signed [ACC_WIDTH-1:0] s;
  // Level l reads the registered outputs of level l-1; level 0 reads the sign-extended ports.
  always_comb begin
    for (int l = 0; l < LEVELS; l++)
      for (int j = 0; j < W; j++) src[l][j] = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      src[0][i] = ACC_WIDTH'($signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]));
    src[0][NUM_INPUTS] = ACC_WIDTH'($signed(bias));
    for (int l = 1; l < LEVELS; l++)
      for (int j = 0; j < W; j++) src[l][j] = stg[l-1][j];
  end
  // Pair adjacent operands; an odd trailing operand passes through so every path sees the same latency.
  always_comb begin
    for (int l = 0; l < LEVELS; l++)
      for (int j = 0; j < W; j++) nxt[l][j] = '0;
    for (int l = 0; l < LEVELS; l++)
      for (int j = 0; j < (OPS + 1) / 2; j++)
        nxt[l][j] = (2*j + 1 < cnt_in(l)) ? src[l][2*j] + src[l][2*j+1] :
                    (2*j < cnt_in(l)) ? src[l][2*j] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int l = 0; l < LEVELS; l++)
        for (int j = 0; j < W; j++) stg[l][j] <= '0;
    end else if (advance) begin
      vld <= LEVELS'({vld, valid_in});
      stg <= nxt;
    end
  end
  assign s = stg[LEVELS-1][0];
  assign valid_out = vld[LEVELS-1];
  assign advance = ~valid_out | ready_out;
  assign ready_in = advance;
  // In range exactly when the bits above the DATA_WIDTH sign bit all equal it.
  assign overflow = ~(&s[ACC_WIDTH-1:DATA_WIDTH-1] | ~|s[ACC_WIDTH-1:DATA_WIDTH-1]);
  assign result = (SATURATE != 0 && overflow) ?
                  (s[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}}) :
                  s[DATA_WIDTH-1:0];
endmodule
